bludger_controller: RTL

Autonomous bludger ball for the quidditch field: it moves diagonally, bounces off the field boundaries and detects contact with either of two players. On contact it drives that player's `bludged` line and holds it until the player's controller returns `clean_bludge`, which ends the player's freeze countdown. It then retreats for a cooldown before it can hit again. It is the initiating end of the bludged/clean_bludge handshake and sits in the game controller next to the player controllers; its position outputs also feed the VGA renderer.

---
 rtl/quidditch_pkg.sv | 51 +++++
 rtl/circle_hit_detect.sv | 34 +++
 rtl/bludger_controller.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/quidditch_pkg.sv
// Shared quidditch game definitions: FSM encoding, field geometry and the
// per-axis bounce/step helper used by moving objects.
package quidditch_pkg;

  localparam logic [1:0] ST_ROAM     = 2'd0;
  localparam logic [1:0] ST_HIT      = 2'd1;
  localparam logic [1:0] ST_COOLDOWN = 2'd2;

  localparam int FIELD_LEFT  = 0;
  localparam int FIELD_RIGHT = 639;
  localparam int FIELD_TOP   = 0;
  localparam int FIELD_BOT   = 479;

  localparam int BALL_RADIUS_PX   = 10;
  localparam int PLAYER_RADIUS_PX = 25;

  typedef logic [9:0] coord_t;

  // One axis of a moving object: direction (1 = increasing) and centre.
  typedef struct packed {
    logic   dir;
    coord_t pos;
  } axis_t;

  // Advance one axis by a single pixel. If the edge of the object would pass
  // the limit, the direction flips and the pixel is taken the other way.
  function automatic axis_t axis_step(input axis_t cur, input int lo,
                                      input int hi, input int radius);
    axis_t nxt;
    int    p;
    p   = int'(cur.pos);
    nxt = cur;
    if (cur.dir) begin
      if (p + 1 + radius > hi) begin
        nxt.dir = 1'b0;
        nxt.pos = cur.pos - 10'd1;
      end else begin
        nxt.pos = cur.pos + 10'd1;
      end
    end else begin
      if (p - 1 - radius < lo) begin
        nxt.dir = 1'b1;
        nxt.pos = cur.pos + 10'd1;
      end else begin
        nxt.pos = cur.pos - 10'd1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/circle_hit_detect.sv
// Combinational overlap test between two circles: strict inequality on the
// squared centre distance against the squared sum of radii.
module circle_hit_detect #(
  parameter int R_A = 10,
  parameter int R_B = 25
) (
  input  logic [9:0] i_a_x,
  input  logic [9:0] i_a_y,
  input  logic [9:0] i_b_x,
  input  logic [9:0] i_b_y,
  output logic       o_hit
);

  localparam logic [22:0] LIMIT = 23'((R_A + R_B) * (R_A + R_B));

  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic signed [21:0] w_dx_ext;
  logic signed [21:0] w_dy_ext;
  logic        [21:0] w_dx_sq;
  logic        [21:0] w_dy_sq;
  logic        [22:0] w_sum;

  assign w_dx     = $signed({1'b0, i_a_x}) - $signed({1'b0, i_b_x});
  assign w_dy     = $signed({1'b0, i_a_y}) - $signed({1'b0, i_b_y});
  assign w_dx_ext = 22'(w_dx);
  assign w_dy_ext = 22'(w_dy);
  // 10-bit differences square to at most 1023^2, which fits 22 bits unsigned.
  assign w_dx_sq  = 22'(w_dx_ext * w_dx_ext);
  assign w_dy_sq  = 22'(w_dy_ext * w_dy_ext);
  assign w_sum    = {1'b0, w_dx_sq} + {1'b0, w_dy_sq};
  assign o_hit    = (w_sum < LIMIT);

endmodule

// File: rtl/bludger_controller.sv
// Autonomous bludger: diagonal motion with boundary bounce, player contact
// detection and the bludged / clean_bludge release handshake.
import quidditch_pkg::*;

module bludger_controller #(
  parameter int          BALL_RADIUS        = BALL_RADIUS_PX,
  parameter int          PLAYER_RADIUS      = PLAYER_RADIUS_PX,
  parameter logic [9:0]  INITIAL_X          = 10'd320,
  parameter logic [9:0]  INITIAL_Y          = 10'd240,
  parameter int          MOVEMENT_FREQUENCY = 200000,
  parameter int          LEFT_BOUNDARY      = FIELD_LEFT,
  parameter int          RIGHT_BOUNDARY     = FIELD_RIGHT,
  parameter int          TOP_BOUNDARY       = FIELD_TOP,
  parameter int          BOT_BOUNDARY       = FIELD_BOT,
  parameter int          COOLDOWN_STEPS     = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] p0_x,
  input  logic [9:0] p0_y,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  input  logic       clean_bludge0,
  input  logic       clean_bludge1,
  output logic [9:0] bludger_x,
  output logic [9:0] bludger_y,
  output logic       bludged0,
  output logic       bludged1,
  output logic [7:0] hit_count
);

  localparam int TICK_W = $clog2(MOVEMENT_FREQUENCY);
  localparam int COOL_W = (COOLDOWN_STEPS < 1) ? 1 : $clog2(COOLDOWN_STEPS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MOVEMENT_FREQUENCY - 1);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_STEPS);

  logic [1:0]        r_state;
  logic [TICK_W-1:0] r_tick;
  logic [COOL_W-1:0] r_cool;
  axis_t             r_ax;
  axis_t             r_ay;
  logic              r_target;
  logic              r_bludged0;
  logic              r_bludged1;
  logic [7:0]        r_hits;

  logic              w_step;
  logic              w_hit0;
  logic              w_hit1;
  logic              w_clean;
  axis_t             w_ax_next;
  axis_t             w_ay_next;

  assign w_step    = (r_tick == TICK_LAST);
  assign w_ax_next = axis_step(r_ax, LEFT_BOUNDARY, RIGHT_BOUNDARY, BALL_RADIUS);
  assign w_ay_next = axis_step(r_ay, TOP_BOUNDARY, BOT_BOUNDARY, BALL_RADIUS);
  assign w_clean   = r_target ? clean_bludge1 : clean_bludge0;

  circle_hit_detect #(
    .R_A(BALL_RADIUS),
    .R_B(PLAYER_RADIUS)
  ) u_hit0 (
    .i_a_x(r_ax.pos),
    .i_a_y(r_ay.pos),
    .i_b_x(p0_x),
    .i_b_y(p0_y),
    .o_hit(w_hit0)
  );

  circle_hit_detect #(
    .R_A(BALL_RADIUS),
    .R_B(PLAYER_RADIUS)
  ) u_hit1 (
    .i_a_x(r_ax.pos),
    .i_a_y(r_ay.pos),
    .i_b_x(p1_x),
    .i_b_y(p1_y),
    .o_hit(w_hit1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ROAM;
      r_tick     <= '0;
      r_cool     <= '0;
      r_ax       <= '{dir: 1'b1, pos: INITIAL_X};
      r_ay       <= '{dir: 1'b1, pos: INITIAL_Y};
      r_target   <= 1'b0;
      r_bludged0 <= 1'b0;
      r_bludged1 <= 1'b0;
      r_hits     <= '0;
    end else begin
      case (r_state)
        ST_ROAM: begin
          // Contact wins over a coincident step: the ball freezes where it is.
          if (w_hit0 || w_hit1) begin
            r_state    <= ST_HIT;
            r_target   <= ~w_hit0;
            r_bludged0 <= w_hit0;
            r_bludged1 <= ~w_hit0;
            r_tick     <= '0;
            if (r_hits != 8'hFF) begin
              r_hits <= r_hits + 8'd1;
            end
          end else begin
            r_tick <= w_step ? '0 : r_tick + 1'b1;
            if (w_step) begin
              r_ax <= w_ax_next;
              r_ay <= w_ay_next;
            end
          end
        end
        ST_HIT: begin
          // The tick counter stays parked at zero while frozen.
          if (w_clean) begin
            r_state    <= ST_COOLDOWN;
            r_bludged0 <= 1'b0;
            r_bludged1 <= 1'b0;
            r_ax.dir   <= ~r_ax.dir;
            r_ay.dir   <= ~r_ay.dir;
            r_cool     <= COOL_LOAD;
          end
        end
        ST_COOLDOWN: begin
          r_tick <= w_step ? '0 : r_tick + 1'b1;
          if (w_step) begin
            r_ax <= w_ax_next;
            r_ay <= w_ay_next;
            if (r_cool <= COOL_W'(1)) begin
              r_state <= ST_ROAM;
              r_cool  <= '0;
            end else begin
              r_cool <= r_cool - 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_ROAM;
        end
      endcase
    end
  end

  assign bludger_x = r_ax.pos;
  assign bludger_y = r_ay.pos;
  assign bludged0  = r_bludged0;
  assign bludged1  = r_bludged1;
  assign hit_count = r_hits;

endmodule
